// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and types for the clearable dual-port RAM
// Purpose: read-during-write mode codes, clear sequencer state type, counter sizing helper.
// Ports: none (package).
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Clear counter / array index width: clog2(depth), never below 1 bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// rtl/ram_clr_seq.sv - zero-sweep sequencer for the dual-port RAM
// Purpose: walks addresses 0..DEPTH-1 issuing zero writes after reset or on request.
// Ports:
//   i_clk       clock
//   i_rst       asynchronous active-high reset
//   i_clr_req   single-cycle sweep request (ignored while a sweep runs)
//   o_busy      high while the sweep runs
//   o_clr_we    zero-write strobe for the array
//   o_clr_addr  address being cleared this cycle
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int CLR_ON_RST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam clr_state_t RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;

  clr_state_t       r_state;
  clr_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; the counter parks at 0 so a new sweep always starts at address 0
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    o_busy     = (r_state == CLEAR);
    o_clr_we   = (r_state == CLEAR);
    o_clr_addr = ADDR_W'(r_cnt);
  end

endmodule

// File: rtl/ram_dp_clr.sv
// rtl/ram_dp_clr.sv - simple dual-port RAM with byte enables and hardware clear
// Purpose: one byte-enabled write port, one registered read port, zero sweep on reset/request.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_clr_req / o_busy  sweep request pulse / sweep in progress
//   i_wr_en, i_wr_addr, i_wr_data, i_wr_be   write port (be bit k -> byte k)
//   i_rd_en, i_rd_addr  read request
//   o_rd_data, o_rd_valid  read result, one cycle after an accepted read
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int RDW_MODE   = RDW_READ_FIRST,
  parameter int CLR_ON_RST = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr_req,
  output logic                o_busy,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_be,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_rd_valid
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = cnt_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // No reset on the array: the clear sequencer is the only way to zero it.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_in_rng;
  logic              w_rd_in_rng;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_old;
  logic [DATA_W-1:0] w_rd_next;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  ram_clr_seq #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_seq (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr_req  (i_clr_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign o_busy = w_busy;

  assign w_wr_in_rng = ({1'b0, i_wr_addr} < DEPTH_L);
  assign w_rd_in_rng = ({1'b0, i_rd_addr} < DEPTH_L);
  assign w_wr_idx    = i_wr_addr[IDX_W-1:0];
  assign w_rd_idx    = i_rd_addr[IDX_W-1:0];

  // A clear request landing in IDLE swallows any user access in the same cycle.
  assign w_wr_acc = i_wr_en && !w_busy && !i_clr_req && w_wr_in_rng;
  assign w_rd_acc = i_rd_en && !w_busy && !i_clr_req;

  assign w_rd_old = w_rd_in_rng ? r_mem[w_rd_idx] : '0;

  // Write-first collision: forward the enabled bytes of the incoming write.
  always_comb begin
    w_rd_next = w_rd_old;
    if ((RDW_MODE == RDW_WRITE_FIRST) && w_wr_acc && (i_wr_addr == i_rd_addr)) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          w_rd_next[8*k +: 8] = i_wr_data[8*k +: 8];
        end
      end
    end
  end

  // Array write: sweep zero-writes take the port ahead of the user write.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr[IDX_W-1:0]] <= '0;
    end else if (w_wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          r_mem[w_wr_idx][8*k +: 8] <= i_wr_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_next;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one independent read port, one clock. Successor to the 64x8 single-port RAM. Generalised in width and depth, with a selectable read-during-write mode and a hardware clear sequencer. The sequencer sweeps the array to zero after reset or on request, so the array itself needs no reset fan-out. Used as a general scratch/buffer memory in datapath blocks.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8.
ADDR_W, 6, address width in bits.
DEPTH, 64, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
RDW_MODE, 0, same-address read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new merged data).
CLR_ON_RST, 1, 1 = start a clear sweep on reset release; 0 = come out of reset idle with array contents undefined.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
clr_req  in  1  single-cycle pulse; requests a zero sweep of the whole array
busy  out  1  high while the clear sweep runs
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit k qualifies wr_data[8k+7:8k]
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data
rd_valid  out  1  high one cycle after an accepted read

Behaviour:
- Reset (async assert): rd_data=0, rd_valid=0, clear counter=0. State = CLEAR if CLR_ON_RST=1 (busy=1 immediately), else IDLE (busy=0). The array is not touched by reset.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR when clr_req=1. busy=1 from the next cycle. Counter starts at 0.
- CLEAR: writes all-zero to mem[cnt] each cycle, then cnt++. After writing address DEPTH-1, the FSM goes to IDLE and busy=0 on the following cycle. A sweep takes exactly DEPTH cycles with busy high.
- clr_req during CLEAR is ignored; the sweep does not restart.
- clr_req in IDLE has priority: wr_en and rd_en in that same cycle are dropped (no write, rd_valid stays 0).
- While busy=1, wr_en and rd_en are ignored. rd_valid=0 and rd_data holds its value.
- Write: when accepted (wr_en=1, not busy, wr_addr < DEPTH), each byte lane with wr_be[k]=1 is updated at the clock edge. wr_be=0 makes the write a no-op.
- Read: when accepted (rd_en=1, not busy), rd_data and rd_valid=1 appear on the next cycle (latency 1). rd_valid is a single-cycle pulse per read. rd_data holds its last value when no read is accepted.
- Same-address collision (both accepted, wr_addr==rd_addr):
  - READ_FIRST: rd_data = pre-write word.
  - WRITE_FIRST: rd_data = old word with the enabled bytes replaced by wr_data.
- Out of range (DEPTH < 2**ADDR_W, address >= DEPTH): the write is dropped; the read returns 0 with rd_valid=1.
- Reset mid-sweep: the counter returns to 0. The sweep restarts from address 0 if CLR_ON_RST=1, else the block goes IDLE with a partially cleared array.
- Counter width: clog2(DEPTH), minimum 1. No wrap beyond DEPTH-1.

Decomposition:
- Shared package ram_pkg: RDW_READ_FIRST=0, RDW_WRITE_FIRST=1 constants; clr_state_t enum {IDLE, CLEAR}.
- One sub-module, ram_clr_seq: the FSM plus counter. Outputs busy, clr_we and clr_addr. The top level muxes the clear write ahead of the user write port.

Test Plan:
- Reset with CLR_ON_RST=1, defaults -> busy high for exactly 64 cycles after rst falls. Then reading addresses 0..63 returns 0x00 each with rd_valid one cycle after rd_en.
- Write 0xA5 to addr 5, then read addr 5 next cycle -> rd_data=0xA5 at latency 1. Reading addr 6 gives 0x00.
- DATA_W=32: write 0x11223344 with wr_be=4'b1111 to addr 3, then 0xAABBCCDD with wr_be=4'b0101 -> read gives 0x11BB33DD.
- Collision: mem[7]=0x10, same-cycle write 0x20 and read addr 7 -> RDW_MODE=0 gives 0x10, RDW_MODE=1 gives 0x20. Next read gives 0x20 in both modes.
- clr_req with simultaneous wr_en to addr 2 (value 0x55), and rd_en asserted during busy -> write dropped, no rd_valid while busy, addr 2 reads 0x00 after the sweep.
- DEPTH=48, ADDR_W=6: write 0x77 to addr 50 -> no effect on any word. Reading addr 50 gives 0x00 with rd_valid=1. Assert rst at sweep cycle 20 -> sweep restarts and busy lasts a full 48 cycles.
